// File: rtl/c7bicu_pkg.sv
// Shared definitions for the c7b instruction-side bus interface unit.
package c7b_icu_pkg;

    localparam int unsigned ICU_DATA_W  = 64;
    localparam int unsigned BUS_DW      = 32;
    localparam int unsigned FETCH_ALIGN = 3;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_IDLE,
        ST_B0_REQ,
        ST_B0_WAIT,
        ST_B1_REQ,
        ST_B1_WAIT,
        ST_RESP
    } icu_state_e;

    // Fetch base: the IFU address with the sub-packet byte offset cleared.
    function automatic logic [31:0] fetch_base(input logic [31:0] addr);
        return {addr[31:FETCH_ALIGN], {FETCH_ALIGN{1'b0}}};
    endfunction

endpackage

// File: rtl/c7bicu_if.sv
// IFU fetch port and system memory read port of the ICU, bundled together.
interface c7bicu_if;
    import c7b_icu_pkg::*;

    // IFU side
    logic                  ifu_icu_req_ic1;
    logic [31:0]           ifu_icu_addr_ic1;
    logic                  icu_ifu_ack_ic1;
    logic                  icu_ifu_data_valid_ic2;
    logic [ICU_DATA_W-1:0] icu_ifu_data_ic2;

    // memory bus side
    logic                  icu_bus_req;
    logic [31:0]           icu_bus_addr;
    logic                  bus_icu_ack;
    logic                  bus_icu_rvalid;
    logic [BUS_DW-1:0]     bus_icu_rdata;
    logic                  bus_icu_rerr;
    logic                  icu_bus_err;

    // ICU view
    modport slave (
        input  ifu_icu_req_ic1, ifu_icu_addr_ic1,
        input  bus_icu_ack, bus_icu_rvalid, bus_icu_rdata, bus_icu_rerr,
        output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
        output icu_bus_req, icu_bus_addr, icu_bus_err
    );

    // IFU + memory view
    modport master (
        output ifu_icu_req_ic1, ifu_icu_addr_ic1,
        output bus_icu_ack, bus_icu_rvalid, bus_icu_rdata, bus_icu_rerr,
        input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
        input  icu_bus_req, icu_bus_addr, icu_bus_err
    );

endinterface

// File: rtl/c7bicu.sv
// Instruction-side responder: turns one 8-byte IFU fetch into two 32-bit
// bus reads and returns the assembled 64-bit packet. One fetch in flight.
module c7bicu
    import c7b_icu_pkg::*;
#(
    parameter logic [BUS_DW-1:0] ERR_WORD  = 32'h0000_0000,
    parameter int unsigned       BOOT_HOLD = 0
) (
    input logic      clk,
    input logic      reset,
    c7bicu_if.slave  icu
);

    localparam icu_state_e RST_STATE = (BOOT_HOLD > 0) ? ST_HOLD : ST_IDLE;

    icu_state_e            state;
    logic [31:0]           hold_cnt;
    logic [31:0]           base;
    logic [BUS_DW-1:0]     lo_word;
    logic                  err_sticky;
    logic                  ack;
    logic                  bus_req_q;
    logic [31:0]           bus_addr_q;
    logic                  data_valid_q;
    logic                  bus_err_q;
    logic [ICU_DATA_W-1:0] data_q;
    logic [BUS_DW-1:0]     beat_word;

    // IFU requests are accepted only when no fetch is in flight (IDLE, or the
    // final RESP cycle of the previous fetch).
    always_comb begin
        ack       = icu.ifu_icu_req_ic1 && ((state == ST_IDLE) || (state == ST_RESP));
        beat_word = icu.bus_icu_rerr ? ERR_WORD : icu.bus_icu_rdata;
    end

    // Two-beat fetch sequencer with registered bus and IFU outputs.
    // The packet and error flag are loaded on the final beat so they are
    // already visible during RESP; the data register then holds until the
    // next packet completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RST_STATE;
            hold_cnt     <= BOOT_HOLD;
            base         <= '0;
            lo_word      <= '0;
            err_sticky   <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            data_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            data_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state)
                ST_HOLD: begin
                    if (hold_cnt <= 32'd1) begin
                        hold_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 32'd1;
                    end
                end
                ST_IDLE, ST_RESP: begin
                    if (ack) begin
                        base       <= fetch_base(icu.ifu_icu_addr_ic1);
                        bus_addr_q <= fetch_base(icu.ifu_icu_addr_ic1);
                        bus_req_q  <= 1'b1;
                        state      <= ST_B0_REQ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_B0_REQ: begin
                    if (icu.bus_icu_ack) begin
                        bus_req_q <= 1'b0;
                        state     <= ST_B0_WAIT;
                    end
                end
                ST_B0_WAIT: begin
                    if (icu.bus_icu_rvalid) begin
                        lo_word    <= beat_word;
                        err_sticky <= err_sticky | icu.bus_icu_rerr;
                        bus_addr_q <= base | 32'd4;
                        bus_req_q  <= 1'b1;
                        state      <= ST_B1_REQ;
                    end
                end
                ST_B1_REQ: begin
                    if (icu.bus_icu_ack) begin
                        bus_req_q <= 1'b0;
                        state     <= ST_B1_WAIT;
                    end
                end
                ST_B1_WAIT: begin
                    if (icu.bus_icu_rvalid) begin
                        data_q       <= {beat_word, lo_word};
                        bus_err_q    <= err_sticky | icu.bus_icu_rerr;
                        err_sticky   <= 1'b0;
                        data_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign icu.icu_ifu_ack_ic1        = ack;
    assign icu.icu_ifu_data_valid_ic2 = data_valid_q;
    assign icu.icu_ifu_data_ic2       = data_q;
    assign icu.icu_bus_req            = bus_req_q;
    assign icu.icu_bus_addr           = bus_addr_q;
    assign icu.icu_bus_err            = bus_err_q;

endmodule

// File: doc/c7bicu.md
Name: c7bicu

Overview:
- Instruction-side responder that terminates the IFU fetch request interface (ic1 request/ack, ic2 64-bit data return).
- Each accepted 8-byte-aligned fetch is split into two 32-bit read beats on a simple req/ack/rvalid memory bus.
- The two words are assembled and returned to the IFU as one 64-bit fetch packet.
- Only one fetch is outstanding at a time. The block sits between the IFU and the system memory bus.

Parameters:
- ERR_WORD, 32'h0000_0000, word substituted for any beat returned with bus error.
- BOOT_HOLD, 0, cycles after reset deassertion during which no IFU request is acked (0 = ack immediately).

Ports:
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ifu_icu_req_ic1  in  1  IFU fetch request valid
- ifu_icu_addr_ic1  in  32  fetch address; bits [2:0] ignored
- icu_ifu_ack_ic1  out  1  request accepted this cycle
- icu_ifu_data_valid_ic2  out  1  one-cycle pulse, fetch data valid
- icu_ifu_data_ic2  out  64  fetch data; [31:0] = word at addr, [63:32] = word at addr+4
- icu_bus_req  out  1  bus read request
- icu_bus_addr  out  32  bus word address, bits [1:0] = 0
- bus_icu_ack  in  1  bus accepted request
- bus_icu_rvalid  in  1  read data valid
- bus_icu_rdata  in  32  read data
- bus_icu_rerr  in  1  read error, qualified by rvalid
- icu_bus_err  out  1  one-cycle pulse when a delivered packet contained at least one error beat

Behaviour:

Reset values (async):
- State IDLE; all outputs 0; data registers 0.
- Hold counter loaded with BOOT_HOLD.

States and transitions:
- HOLD: entered only if BOOT_HOLD > 0. Counts down; goes to IDLE when the count reaches 0. No ack is given in HOLD.
- IDLE: ack = req (combinational). On ack, latch {addr[31:3], 3'b000} and go to B0_REQ.
- B0_REQ: icu_bus_req = 1, icu_bus_addr = base. On bus_icu_ack, go to B0_WAIT.
- B0_WAIT: on rvalid, capture lo = rerr ? ERR_WORD : rdata, OR rerr into the sticky err flag, and go to B1_REQ.
- B1_REQ: icu_bus_req = 1, icu_bus_addr = base + 4. On bus_icu_ack, go to B1_WAIT.
- B1_WAIT: on rvalid, capture hi (same error rule) and go to RESP.
- RESP:
  - data_valid = 1 and icu_ifu_data_ic2 = {hi, lo}.
  - icu_bus_err = sticky err; sticky err is then cleared.
  - ack = req. If acked, latch the new base and go to B0_REQ; otherwise go to IDLE.

Rules and boundary conditions:
- Ack is never asserted in B0_REQ..B1_WAIT or HOLD. The IFU holds req/addr until acked.
- rvalid in the same cycle as the bus ack is not permitted by the bus; it is ignored.
- rvalid outside the WAIT states is ignored.
- Zero-wait bus latency: ack at T, B0_REQ at T+1, data at T+2, B1_REQ at T+3, data at T+4, data_valid at T+5. The next ack can occur at T+5.
- icu_ifu_data_ic2 holds its last value outside RESP. It is not zeroed.
- base + 4 never crosses an 8-byte boundary, so no carry out of bit 2.
- Address 32'hFFFF_FFF8: beats go to 32'hFFFF_FFF8 and 32'hFFFF_FFFC, with no wrap handling needed.
- Reset mid-fetch: immediate return to IDLE/HOLD; icu_bus_req drops asynchronously. Partial data is discarded and no data_valid is issued.
- IFU flush: there is no cancel port. The fetch completes and the IFU discards it.

Decomposition:
- Shared package c7b_icu_pkg:
  - state encoding (HOLD, IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP)
  - ICU_DATA_W = 64
  - BUS_DW = 32
  - FETCH_ALIGN = 3
- Registers use the existing dffe/dffrle-style flop cells with async active-high reset.
- No sub-module needed. The two-beat sequencer is a single FSM plus a 64-bit assembly register.

Test Plan:
- Zero-wait bus, req addr 32'h1C00_0000, memory words 0x0280_0000/0x0280_0401 -> ack same cycle; bus addrs 1C00_0000 then 1C00_0004; data_valid at T+5 with 64'h0280_0401_0280_0000.
- req addr 32'h1C00_000D -> bus addrs 1C00_0008, 1C00_000C (low bits ignored).
- Back-to-back reqs 1C00_0000, 1C00_0008 held high -> second ack coincides with first data_valid; no ack during the B-states; two data_valid pulses 5 cycles apart.
- Bus ack stalled 3 cycles on beat 0 and rvalid delayed 4 cycles on beat 1 -> icu_bus_req/addr stable while waiting; single data_valid with correct data.
- rerr on beat 1 with ERR_WORD default -> data[63:32] = 0, icu_bus_err pulses with data_valid; the next clean fetch has icu_bus_err = 0.
- reset asserted in B1_WAIT -> icu_bus_req = 0 immediately, no data_valid. With BOOT_HOLD = 4, req is not acked until the 5th cycle after release.
